// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Two-requester APB master. Round-robin arbitration between requester 0
// (core load/store) and requester 1 (debug/DMA), APB IDLE/SETUP/ACCESS
// sequencing toward the interconnect, and an optional PREADY timeout.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/write   per-requester request and direction (1=write)
//   req_addr/wdata    per-requester address/data, requester i at [i*W +: W]
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   resp_valid        one-cycle completion pulse to the granted requester
//   resp_rdata/err    read data / error, valid with resp_valid
//   paddr..penable    APB master outputs toward the interconnect
//   prdata/pready/pslverr  APB slave-side returns
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic                psel,
    output logic                penable,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    // Counter only has to reach TIMEOUT-1: the abort fires on the edge that
    // closes the TIMEOUT-th wait cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state, state_nxt;
    logic               last_grant;   // also identifies the in-flight owner
    logic               gnt;
    logic               any_req;
    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt;

    // Arbitration: single request wins outright, a tie goes to whoever did
    // not win last time.
    always_comb begin
        any_req     = |req_valid;
        gnt         = (&req_valid) ? ~last_grant : req_valid[1];
        timeout_hit = (TIMEOUT != 0) && !pready && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: accept strobe only
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && any_req) req_ready[gnt] = 1'b1;
    end

    // Registered APB outputs, response and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        paddr      <= gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                        pwdata     <= gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        pwrite     <= req_write[gnt];
                        last_grant <= gnt;
                        psel       <= 1'b1;
                        cnt        <= '0;
                    end
                end
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    if (pready) begin
                        resp_valid[last_grant] <= 1'b1;
                        resp_rdata <= pwrite ? '0 : prdata;
                        resp_err   <= pslverr;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_valid[last_grant] <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv, rw;
    logic [19:0] a0, a1;
    logic [31:0] wd0, wd1;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [19:0] paddr;
    logic        pwrite, psel, penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_master_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_write(rw),
        .req_addr({a1, a0}), .req_wdata({wd1, wd0}),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // One row = inputs for a cycle plus outputs expected just before its edge.
    typedef struct {
        logic [1:0]  rv;
        logic        rdy;
        logic [31:0] prd;
        logic [1:0]  rr;
        logic        psel;
        logic        pen;
        logic [1:0]  rsv;
        logic [31:0] rsd;
        logic [19:0] paddr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] v, input logic r, input logic [31:0] p,
                       input logic [1:0] rr_e, input logic ps, input logic pe,
                       input logic [1:0] rs, input logic [31:0] rd, input logic [19:0] pa);
        vec_t e;
        e.rv = v; e.rdy = r; e.prd = p; e.rr = rr_e; e.psel = ps; e.pen = pe;
        e.rsv = rs; e.rsd = rd; e.paddr = pa;
        tbl.push_back(e);
    endtask

    initial begin
        int n;
        rst = 1'b0; rv = 2'b00; rw = 2'b00;
        a0 = 20'h06010; a1 = 20'h0A000; wd0 = 32'h0; wd1 = 32'h11112222;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

        // contention from reset (both held), then single read on req 0,
        // then four back-to-back reads on req 1 with pready always high
        add(2'b11,0,32'h0,        2'b01,0,0,2'b00,32'h0,        20'h00000);
        add(2'b11,0,32'h0,        2'b00,1,0,2'b00,32'h0,        20'h06010);
        add(2'b11,1,32'h11111111, 2'b00,1,1,2'b00,32'h0,        20'h06010);
        add(2'b11,0,32'h0,        2'b10,0,0,2'b01,32'h11111111, 20'h06010);
        add(2'b00,0,32'h0,        2'b00,1,0,2'b00,32'h11111111, 20'h0A000);
        add(2'b00,1,32'h22222222, 2'b00,1,1,2'b00,32'h11111111, 20'h0A000);
        add(2'b00,0,32'h0,        2'b00,0,0,2'b10,32'h22222222, 20'h0A000);
        add(2'b01,0,32'h0,        2'b01,0,0,2'b00,32'h22222222, 20'h0A000);
        add(2'b00,0,32'h0,        2'b00,1,0,2'b00,32'h22222222, 20'h06010);
        add(2'b00,1,32'hDEADBEEF, 2'b00,1,1,2'b00,32'h22222222, 20'h06010);
        add(2'b00,0,32'h0,        2'b00,0,0,2'b01,32'hDEADBEEF, 20'h06010);
        add(2'b10,1,32'h0,        2'b10,0,0,2'b00,32'hDEADBEEF, 20'h06010);
        add(2'b10,1,32'h0,        2'b00,1,0,2'b00,32'hDEADBEEF, 20'h0A000);
        add(2'b10,1,32'h30000001, 2'b00,1,1,2'b00,32'hDEADBEEF, 20'h0A000);
        add(2'b10,1,32'h0,        2'b10,0,0,2'b10,32'h30000001, 20'h0A000);
        add(2'b10,1,32'h0,        2'b00,1,0,2'b00,32'h30000001, 20'h0A000);
        add(2'b10,1,32'h30000002, 2'b00,1,1,2'b00,32'h30000001, 20'h0A000);
        add(2'b10,1,32'h0,        2'b10,0,0,2'b10,32'h30000002, 20'h0A000);
        add(2'b10,1,32'h0,        2'b00,1,0,2'b00,32'h30000002, 20'h0A000);
        add(2'b10,1,32'h30000003, 2'b00,1,1,2'b00,32'h30000002, 20'h0A000);
        add(2'b10,1,32'h0,        2'b10,0,0,2'b10,32'h30000003, 20'h0A000);
        add(2'b10,1,32'h0,        2'b00,1,0,2'b00,32'h30000003, 20'h0A000);
        add(2'b10,1,32'h30000004, 2'b00,1,1,2'b00,32'h30000003, 20'h0A000);
        add(2'b00,1,32'h0,        2'b00,0,0,2'b10,32'h30000004, 20'h0A000);
        add(2'b00,0,32'h0,        2'b00,0,0,2'b00,32'h30000004, 20'h0A000);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_pen", penable, 0);
        chk("rst_rsv", resp_valid, 0);
        chk("rst_rsd", resp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            rv = tbl[i].rv; pready = tbl[i].rdy; prdata = tbl[i].prd;
            #1;
            chk($sformatf("v%0d_rr", i),    req_ready,  tbl[i].rr);
            chk($sformatf("v%0d_psel", i),  psel,       tbl[i].psel);
            chk($sformatf("v%0d_pen", i),   penable,    tbl[i].pen);
            chk($sformatf("v%0d_rsv", i),   resp_valid, tbl[i].rsv);
            chk($sformatf("v%0d_rsd", i),   resp_rdata, tbl[i].rsd);
            chk($sformatf("v%0d_rse", i),   resp_err,   0);
            chk($sformatf("v%0d_paddr", i), paddr,      tbl[i].paddr);
            @(negedge clk);
        end

        // write with 3 wait states then slave error
        a0 = 20'h08004; wd0 = 32'h0000A5A5; rw = 2'b01; rv = 2'b01; pready = 0;
        #1 chk("we_rr", req_ready, 2'b01);
        @(negedge clk);
        rv = 2'b00; rw = 2'b00;
        chk("we_setup", {psel, penable}, 2'b10);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pready = (i == 3); pslverr = (i == 3); prdata = 32'hFFFFFFFF;
            #1;
            chk($sformatf("we_acc%0d", i), {psel, penable, pwrite}, 3'b111);
            chk($sformatf("we_addr%0d", i), paddr, 20'h08004);
            chk($sformatf("we_wd%0d", i), pwdata, 32'h0000A5A5);
            chk($sformatf("we_rsv%0d", i), resp_valid, 0);
            @(negedge clk);
        end
        pready = 0; pslverr = 0;
        chk("we_rsv", resp_valid, 2'b01);
        chk("we_rse", resp_err, 1);
        chk("we_rsd", resp_rdata, 0);
        chk("we_psel", psel, 0);

        // timeout on requester 1
        rv = 2'b10; prdata = 32'h55555555;
        #1 chk("to_rr", req_ready, 2'b10);
        @(negedge clk);
        rv = 2'b00;
        @(negedge clk);
        n = 0;
        while (psel && penable && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, 16);
        chk("to_psel", {psel, penable}, 2'b00);
        chk("to_rsv", resp_valid, 2'b10);
        chk("to_rse", resp_err, 1);
        chk("to_rsd", resp_rdata, 0);

        // next request after timeout completes normally
        a0 = 20'h06010; rv = 2'b01;
        #1 chk("nx_rr", req_ready, 2'b01);
        @(negedge clk);
        rv = 2'b00;
        @(negedge clk);
        pready = 1; prdata = 32'h12345678;
        @(negedge clk);
        pready = 0;
        chk("nx_rsv", resp_valid, 2'b01);
        chk("nx_rsd", resp_rdata, 32'h12345678);
        chk("nx_rse", resp_err, 0);

        // reset while in ACCESS with pready low
        rv = 2'b11;
        #1 chk("rs_rr", req_ready, 2'b10);
        @(negedge clk);
        rv = 2'b00;
        @(negedge clk);
        chk("rs_acc", {psel, penable}, 2'b11);
        rst = 1'b0;
        #1;
        chk("rs_psel", {psel, penable}, 2'b00);
        chk("rs_rsv", resp_valid, 0);
        @(negedge clk);
        rst = 1'b1; rv = 2'b11;
        #1 chk("rs_tie", req_ready, 2'b01);
        chk("rs_rsv2", resp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
